multicycle_controller: RTL

Parametrised control unit for the multicycle RV32I datapath, covering the full RV32I base set except FENCE/SYSTEM. It adds JALR, LUI, AUIPC and all six branch conditions, plus configurable memory wait states, an illegal-instruction trap and optional M-extension ALU decode. It sits between the instruction register and the datapath muxes and register/memory write enables.

---
 rtl/multicycle_controller.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: FSM with memory wait states and an illegal-instruction trap.
// Defining MULTICYCLE_CONTROLLER_MUL_EN adds M-extension multiply decode on R-type.
module multicycle_controller #(
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int MEM_LATENCY    = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic                      zero,
    input  logic                      lt,
    input  logic                      ltu,
    output logic                      pc_write,
    output logic                      address_source,
    output logic                      memory_write,
    output logic                      ir_write,
    output logic                      register_write,
    output logic [1:0]                result_source,
    output logic [1:0]                alu_source_a,
    output logic [1:0]                alu_source_b,
    output logic [2:0]                immediate_source,
    output logic [ALU_CTRL_WIDTH-1:0] alu_control,
    output logic                      illegal_instruction
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_JAL, S_JALR, S_JALRJ, S_BRANCH, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LATENCY);

    state_t     state, cur, state_next;
    logic [3:0] wait_count;
    logic       wait_done;
    logic       is_mul, r_legal, branch_taken, branch_bad;
    logic [3:0] exec_op, alu_sel;
    logic       fsm_pc_write, fsm_memory_write, fsm_ir_write, fsm_register_write;

    // Reset forces the FETCH view of the outputs in the same cycle it is asserted.
    assign cur       = reset ? S_FETCH : state;
    assign wait_done = (wait_count == LAST_WAIT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_FETCH;
            wait_count <= '0;
        end else begin
            state      <= state_next;
            wait_count <= (state_next == state && (state == S_FETCH || state == S_MEMREAD))
                          ? wait_count + 4'd1 : 4'd0;
        end
    end

`ifdef MULTICYCLE_CONTROLLER_MUL_EN
    assign is_mul = (funct7 == 7'b0000001) && !funct3[2];
`else
    assign is_mul = 1'b0;
`endif
    assign r_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000) || is_mul;

    always_comb begin
        exec_op = ALU_ADD;
        case (funct3)
            3'b000: exec_op = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: exec_op = ALU_SLL;
            3'b010: exec_op = ALU_SLT;
            3'b011: exec_op = ALU_SLTU;
            3'b100: exec_op = ALU_XOR;
            3'b101: exec_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: exec_op = ALU_OR;
            3'b111: exec_op = ALU_AND;
            default: exec_op = ALU_ADD;
        endcase
        if (opcode == OP_R && is_mul)
            exec_op = ALU_MUL + {2'b00, funct3[1:0]};
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000: branch_taken = zero;
            3'b001: branch_taken = !zero;
            3'b100: branch_taken = lt;
            3'b101: branch_taken = !lt;
            3'b110: branch_taken = ltu;
            3'b111: branch_taken = !ltu;
            default: branch_taken = 1'b0;
        endcase
    end
    assign branch_bad = (funct3[2:1] == 2'b01);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_next          = cur;
        fsm_pc_write        = 1'b0;
        fsm_memory_write    = 1'b0;
        fsm_ir_write        = 1'b0;
        fsm_register_write  = 1'b0;
        address_source      = 1'b0;
        result_source       = RES_ALUOUT;
        alu_source_a        = SRCA_PC;
        alu_source_b        = SRCB_RS2;
        immediate_source    = IMM_I;
        alu_sel             = ALU_ADD;
        illegal_instruction = 1'b0;
        case (cur)
            S_FETCH: begin
                result_source = RES_ALU;
                alu_source_b  = SRCB_FOUR;
                if (wait_done) begin
                    fsm_ir_write = 1'b1;
                    fsm_pc_write = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_source_a     = SRCA_OLDPC;
                alu_source_b     = SRCB_IMM;
                immediate_source = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = r_legal ? S_EXECR : S_TRAP;
                    OP_I:              state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_source_a     = SRCA_RS1;
                alu_source_b     = SRCB_IMM;
                immediate_source = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_next       = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                address_source = 1'b1;
                if (wait_done)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_source      = RES_MEM;
                fsm_register_write = 1'b1;
                state_next         = S_FETCH;
            end
            S_MEMWRITE: begin
                address_source   = 1'b1;
                fsm_memory_write = 1'b1;
                state_next       = S_FETCH;
            end
            S_EXECR: begin
                alu_source_a = SRCA_RS1;
                alu_source_b = SRCB_RS2;
                alu_sel      = exec_op;
                state_next   = S_ALUWB;
            end
            S_EXECI: begin
                alu_source_a = SRCA_RS1;
                alu_source_b = SRCB_IMM;
                alu_sel      = exec_op;
                state_next   = S_ALUWB;
            end
            S_ALUWB: begin
                fsm_register_write = 1'b1;
                state_next         = S_FETCH;
            end
            // Both jump states load the target held in ALU-out while the ALU forms the link value.
            S_JAL, S_JALRJ: begin
                alu_source_a = SRCA_OLDPC;
                alu_source_b = SRCB_FOUR;
                fsm_pc_write = 1'b1;
                state_next   = S_ALUWB;
            end
            S_JALR: begin
                alu_source_a = SRCA_RS1;
                alu_source_b = SRCB_IMM;
                state_next   = S_JALRJ;
            end
            S_BRANCH: begin
                alu_source_a = SRCA_RS1;
                alu_source_b = SRCB_RS2;
                alu_sel      = ALU_SUB;
                fsm_pc_write = branch_taken;
                state_next   = branch_bad ? S_TRAP : S_FETCH;
            end
            S_LUI: begin
                immediate_source   = IMM_U;
                result_source      = RES_IMM;
                fsm_register_write = 1'b1;
                state_next         = S_FETCH;
            end
            S_AUIPC: begin
                alu_source_a     = SRCA_OLDPC;
                alu_source_b     = SRCB_IMM;
                immediate_source = IMM_U;
                state_next       = S_ALUWB;
            end
            S_TRAP: begin
                illegal_instruction = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    assign pc_write       = fsm_pc_write & ~reset;
    assign ir_write       = fsm_ir_write & ~reset;
    assign register_write = fsm_register_write & ~reset;
    assign memory_write   = fsm_memory_write & ~reset;
    assign alu_control    = ALU_CTRL_WIDTH'(alu_sel);

endmodule
